// File: rtl/ioctl_pkg.sv
// Shared definitions for the HPS ioctl upload (read-back) path.
//   upl_state_t : upload responder session states
//   IOCTL_AW    : width of the host-side ioctl byte address
//   OOR_BYTE    : byte returned for addresses beyond the backing RAM
package ioctl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    READY,
    READ
  } upl_state_t;

  localparam int unsigned IOCTL_AW = 25;
  localparam logic [7:0]  OOR_BYTE = 8'hFF;

endpackage

// File: rtl/ioctl_upload_reader.sv
// Upload-direction responder for the HPS ioctl bus. Serves bytes from a synchronous
// game RAM (NVRAM / hiscore) to the host while it reads back a saved image, pausing
// the game CPU for the duration of the session and keeping a running byte checksum.
//
// Ports:
//   clk_sys, reset_n        system clock, asynchronous active-low reset
//   ioctl_upload            host upload session active
//   ioctl_index             session target index (compared against INDEX)
//   ioctl_rd, ioctl_addr    single-cycle read strobe and its byte address
//   ioctl_din, ioctl_wait   returned byte and stall back to the host
//   pause_req, pause_ack    CPU halt handshake
//   mem_addr, mem_rd, mem_q synchronous RAM read port (data RD_LAT cycles after mem_rd)
//   busy, done              session in progress / one-cycle end-of-session pulse
//   checksum                sum mod 256 of bytes served in current or last session
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter logic [7:0]  INDEX  = 8'd4,
  parameter int unsigned AW     = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic                pause_req,
  input  logic                pause_ack,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_q,
  output logic                busy,
  output logic                done,
  output logic [7:0]          checksum
);

  // READ lasts RD_LAT+1 cycles: the counter is loaded with RD_LAT on entry and the
  // byte is latched in the cycle it reads zero.
  localparam logic [1:0]          LatCnt   = 2'(RD_LAT);
  localparam logic [IOCTL_AW-1:0] DepthLim = IOCTL_AW'(DEPTH);

  upl_state_t          state_q, state_d;
  logic                pend_valid_q, pend_valid_d;
  logic [IOCTL_AW-1:0] pend_addr_q, pend_addr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                oor_q, oor_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [7:0]          din_q, din_d;
  logic [7:0]          checksum_q, checksum_d;
  logic                done_q, done_d;

  logic                start_rd;
  logic [IOCTL_AW-1:0] rd_addr;
  logic                in_range;

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    cnt_d        = cnt_q;
    oor_d        = oor_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_d     = 1'b0;
    din_d        = din_q;
    checksum_d   = checksum_q;
    done_d       = 1'b0;
    start_rd     = 1'b0;
    rd_addr      = ioctl_addr;

    unique case (state_q)
      IDLE: begin
        if (ioctl_upload && (ioctl_index == INDEX)) begin
          state_d      = ACK;
          checksum_d   = 8'h00;
          pend_valid_d = 1'b0;
        end
      end
      ACK: begin
        // One-deep pending slot; a later strobe overwrites an earlier one.
        if (ioctl_rd) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = ioctl_addr;
        end
        if (pause_ack) begin
          pend_valid_d = 1'b0;
          if (ioctl_rd) begin
            start_rd = 1'b1;
            rd_addr  = ioctl_addr;
          end else if (pend_valid_q) begin
            start_rd = 1'b1;
            rd_addr  = pend_addr_q;
          end else begin
            state_d = READY;
          end
        end
      end
      READY: begin
        if (ioctl_rd) begin
          start_rd = 1'b1;
        end
      end
      READ: begin
        // Strobes here violate the wait protocol and are dropped.
        if (cnt_q == 2'd0) begin
          din_d      = oor_q ? OOR_BYTE : mem_q;
          checksum_d = checksum_q + din_d;
          state_d    = READY;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    in_range = (rd_addr < DepthLim);
    if (start_rd) begin
      state_d = READ;
      cnt_d   = LatCnt;
      oor_d   = !in_range;
      if (in_range) begin
        mem_rd_d   = 1'b1;
        mem_addr_d = rd_addr[AW-1:0];
      end
    end

    // Host ended the session: any in-flight byte is discarded.
    if ((state_q != IDLE) && !ioctl_upload) begin
      state_d      = IDLE;
      done_d       = 1'b1;
      mem_rd_d     = 1'b0;
      pend_valid_d = 1'b0;
      din_d        = din_q;
      checksum_d   = checksum_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      cnt_q        <= 2'd0;
      oor_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      din_q        <= 8'h00;
      checksum_q   <= 8'h00;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      cnt_q        <= cnt_d;
      oor_q        <= oor_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      din_q        <= din_d;
      checksum_q   <= checksum_d;
      done_q       <= done_d;
    end
  end

  // Session-level outputs decode straight from state so reset drops them at once.
  always_comb begin
    ioctl_wait = (state_q == ACK) || (state_q == READ);
    pause_req  = (state_q != IDLE);
    busy       = (state_q != IDLE);
  end

  assign ioctl_din = din_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
module tb_ioctl_upload_reader;

  localparam logic [7:0] Index = 8'd4;
  localparam int         Aw    = 10;
  localparam int         Depth = 1024;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        pause_ack = 1'b0;
  logic [Aw-1:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_sum = 8'h00;
  logic [7:0]  ram [0:Depth-1];

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_reader #(
    .INDEX (Index),
    .AW    (Aw),
    .DEPTH (Depth),
    .RD_LAT(1)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ioctl_upload(ioctl_upload),
    .ioctl_index (ioctl_index),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ioctl_wait  (ioctl_wait),
    .pause_req   (pause_req),
    .pause_ack   (pause_ack),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_q       (mem_q),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum)
  );

  // Synchronous RAM, one cycle read latency.
  always_ff @(posedge clk_sys) begin
    if (mem_rd) mem_q <= ram[mem_addr];
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    tick();
    tests++;
    if ({ioctl_din, ioctl_wait, pause_req, mem_addr, mem_rd, busy, done, checksum} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: din=%h wait=%b preq=%b maddr=%h mrd=%b busy=%b done=%b cs=%h, want all 0",
               ioctl_din, ioctl_wait, pause_req, mem_addr, mem_rd, busy, done, checksum);
    end
    reset_n = 1'b1;
    tick();
    tests++;
    if ({ioctl_wait, pause_req, busy, done} !== 4'b0) begin
      fails++;
      $display("FAIL reset_release: wait=%b preq=%b busy=%b done=%b, want 0",
               ioctl_wait, pause_req, busy, done);
    end
  endtask

  task automatic start_session(input int ack_delay);
    ioctl_index  = Index;
    ioctl_upload = 1'b1;
    exp_sum      = 8'h00;
    tick();
    tests++;
    if ({pause_req, busy, ioctl_wait} !== 3'b111 || checksum !== 8'h00) begin
      fails++;
      $display("FAIL session_start: preq=%b busy=%b wait=%b cs=%h, want 1 1 1 00",
               pause_req, busy, ioctl_wait, checksum);
    end
    repeat (ack_delay) tick();
    pause_ack = 1'b1;
    tick();
    tests++;
    if (ioctl_wait !== 1'b0) begin
      fails++;
      $display("FAIL ready_wait: wait=%b, want 0", ioctl_wait);
    end
  endtask

  // Called in the first cycle after the strobe was sampled (cycle T+1).
  task automatic finish_read(input logic [24:0] addr);
    int waits = 0;
    int rds   = 0;
    logic [7:0] exp;
    logic in_range = (addr < Depth);
    if (in_range) begin
      tests++;
      if (mem_rd !== 1'b1 || mem_addr !== addr[Aw-1:0]) begin
        fails++;
        $display("FAIL mem_issue: mem_rd=%b mem_addr=%0d, want 1 %0d", mem_rd, mem_addr, addr);
      end
    end
    while (ioctl_wait === 1'b1 && waits < 10) begin
      if (mem_rd === 1'b1) rds++;
      waits++;
      tick();
    end
    tests++;
    if (waits != 2) begin
      fails++;
      $display("FAIL wait_len addr=%0d: %0d cycles, want 2", addr, waits);
    end
    tests++;
    if (rds != (in_range ? 1 : 0)) begin
      fails++;
      $display("FAIL mem_rd_count addr=%0d: %0d, want %0d", addr, rds, in_range ? 1 : 0);
    end
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty addr=%0d: din=%h with no expected byte", addr, ioctl_din);
    end else begin
      exp = exp_q.pop_front();
      exp_sum = exp_sum + exp;
      if (ioctl_din !== exp) begin
        fails++;
        $display("FAIL din addr=%0d: got %h, want %h", addr, ioctl_din, exp);
      end
    end
    tests++;
    if (checksum !== exp_sum) begin
      fails++;
      $display("FAIL checksum addr=%0d: got %h, want %h", addr, checksum, exp_sum);
    end
  endtask

  task automatic do_read(input logic [24:0] addr);
    exp_q.push_back((addr < Depth) ? ram[addr[Aw-1:0]] : 8'hFF);
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    tick();
    ioctl_rd = 1'b0;
    finish_read(addr);
  endtask

  task automatic end_session();
    ioctl_upload = 1'b0;
    pause_ack    = 1'b0;
    tick();
    tests++;
    if ({done, pause_req, busy, ioctl_wait} !== 4'b1000) begin
      fails++;
      $display("FAIL session_end: done=%b preq=%b busy=%b wait=%b, want 1 0 0 0",
               done, pause_req, busy, ioctl_wait);
    end
    tick();
    tests++;
    if (done !== 1'b0 || checksum !== exp_sum) begin
      fails++;
      $display("FAIL after_end: done=%b cs=%h, want 0 %h", done, checksum, exp_sum);
    end
  endtask

  task automatic test_basic();
    ram[5] = 8'h3C;
    start_session(3);
    do_read(25'd5);
    end_session();
    ram[5] = 8'h05;
  endtask

  task automatic test_early();
    int seen = 0;
    ioctl_index  = Index;
    ioctl_upload = 1'b1;
    exp_sum      = 8'h00;
    tick();
    for (int c = 1; c < 10; c++) begin
      if (mem_rd === 1'b1) seen++;
      ioctl_rd   = (c == 2) || (c == 4);
      ioctl_addr = (c == 2) ? 25'd9 : 25'd7;
      tick();
    end
    ioctl_rd = 1'b0;
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL early_no_mem_rd: %0d mem_rd cycles before ack, want 0", seen);
    end
    exp_q.push_back(ram[7]);
    pause_ack = 1'b1;
    tick();
    finish_read(25'd7);
    do_read(25'd8);
    end_session();
  endtask

  task automatic test_out_of_range();
    start_session(1);
    do_read(25'd1024);
    do_read(25'd1023);
    do_read(25'h1FFFFFF);
    end_session();
  endtask

  task automatic test_back_to_back();
    start_session(2);
    for (int i = 0; i < Depth; i++) do_read(25'(i));
    tests++;
    if (checksum !== 8'h00) begin
      fails++;
      $display("FAIL dump_checksum: got %h, want 00", checksum);
    end
    end_session();
  endtask

  task automatic test_mismatch();
    int bad = 0;
    ioctl_index  = 8'd3;
    ioctl_upload = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ioctl_rd   = c[0];
      ioctl_addr = 25'(c);
      tick();
      if ({pause_req, ioctl_wait, mem_rd, busy, done} !== 5'b0) bad++;
    end
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    tests++;
    if (bad != 0 || done !== 1'b0) begin
      fails++;
      $display("FAIL index_mismatch: %0d active cycles, done=%b, want 0 0", bad, done);
    end
    ioctl_index = Index;
  endtask

  task automatic test_abort();
    logic [7:0] keep_din;
    logic [7:0] keep_cs;
    int dones = 0;
    start_session(2);
    do_read(25'd20);
    keep_din = ram[20];
    keep_cs  = exp_sum;
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd30;
    tick();
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    pause_ack    = 1'b0;
    tests++;
    if (ioctl_wait !== 1'b1) begin
      fails++;
      $display("FAIL abort_in_read: wait=%b, want 1", ioctl_wait);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done === 1'b1) dones++;
      tests++;
      if (ioctl_din !== keep_din || checksum !== keep_cs) begin
        fails++;
        $display("FAIL abort_hold: din=%h cs=%h, want %h %h", ioctl_din, checksum, keep_din, keep_cs);
      end
    end
    tests++;
    if (dones != 1) begin
      fails++;
      $display("FAIL abort_done: %0d pulses, want 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    start_session(1);
    do_read(25'd40);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd50;
    tick();
    ioctl_rd = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({ioctl_din, ioctl_wait, pause_req, mem_addr, mem_rd, busy, done, checksum} !== '0) begin
      fails++;
      $display("FAIL reset_mid: din=%h wait=%b preq=%b maddr=%h mrd=%b busy=%b done=%b cs=%h, want all 0",
               ioctl_din, ioctl_wait, pause_req, mem_addr, mem_rd, busy, done, checksum);
    end
    exp_q.delete();
    ioctl_upload = 1'b0;
    pause_ack    = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    tests++;
    if (dones != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_done: %0d done pulses busy=%b, want 0 0", dones, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) ram[i] = 8'(i);
    test_reset();
    test_basic();
    test_early();
    test_out_of_range();
    test_back_to_back();
    test_mismatch();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ioctl_upload_reader.md
# ioctl_upload_reader

Responder for the upload direction of the HPS ioctl bus: serves bytes from game NVRAM/hiscore RAM to the host when it reads back a saved image. It sits beside the ROM download path in the core top level and owns `ioctl_din`/`ioctl_wait` during an upload session. While a session is active it pauses the game CPU, reads a synchronous RAM port, and reports a running checksum.

## Interface
Parameters:
- `INDEX`, 8'd4: `ioctl_index` value this block answers.
- `AW`, 10: RAM address width.
- `DEPTH`, 1024: valid byte count; must be ≤ 2**AW.
- `RD_LAT`, 1: RAM read latency in cycles; legal values are 1 and 2.

Ports:
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_upload`  in  1  host upload session active.
- `ioctl_index`  in  8  session target index.
- `ioctl_rd`  in  1  single-cycle read strobe.
- `ioctl_addr`  in  25  byte address; valid on the `ioctl_rd` cycle.
- `ioctl_din`  out  8  byte returned to the host.
- `ioctl_wait`  out  1  stall to the host; the host must not pulse `ioctl_rd` while it is high.
- `pause_req`  out  1  CPU halt request.
- `pause_ack`  in  1  CPU halted.
- `mem_addr`  out  AW  RAM read address.
- `mem_rd`  out  1  RAM read enable.
- `mem_q`  in  8  RAM data, valid RD_LAT cycles after `mem_rd`.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse at session end.
- `checksum`  out  8  sum mod 256 of bytes served in the current or last session.

## Operation
- Session start: `ioctl_upload` is high and `ioctl_index == INDEX`, sampled in IDLE. If the index does not match, the block stays IDLE and all outputs hold at 0.
- States:
  - IDLE to ACK on session start. On entry to ACK: `pause_req=1`, `busy=1`, `checksum` cleared.
  - ACK: `ioctl_wait=1`. When `pause_ack=1`, go to READY, or to READ if a request is pending.
  - READY: `ioctl_wait=0`. When `ioctl_rd=1`, go to READ.
  - READ: `ioctl_wait=1`. Runs for RD_LAT+1 cycles, then latches the byte and returns to READY.
  - Any state except IDLE: when `ioctl_upload` falls, go to IDLE with `pause_req=0`, `busy=0`, and `done` pulsed for 1 cycle.
- Pending request: an `ioctl_rd` during ACK stores its address in a one-deep pending register and is serviced right after the ack. A second `ioctl_rd` during ACK overwrites the pending entry (last wins).
- `ioctl_rd` during READ is ignored, because the host is violating the wait protocol.
- Address handling:
  - `ioctl_addr < DEPTH`: drive `mem_addr = ioctl_addr[AW-1:0]` with `mem_rd=1` for exactly 1 cycle.
  - `ioctl_addr >= DEPTH`: `mem_rd` stays 0 and the returned byte is 8'hFF. Latency is unchanged.
- Checksum: on each latched byte, `checksum <= checksum + byte` (8-bit wrap, 0xFF bytes included). It holds its value after the session ends until the next session starts.
- `ioctl_din` holds the last served byte until the next latch or reset.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; every output 0, including `ioctl_din`, `checksum` and `mem_addr`.
- Read latency: `ioctl_rd` sampled high at the end of cycle T, in READY.
  - Cycle T+1: `ioctl_wait=1`, `mem_rd=1`, `mem_addr` valid.
  - `mem_q` is captured at the end of cycle T+1+RD_LAT.
  - From cycle T+2+RD_LAT: `ioctl_din` is valid and `ioctl_wait=0`.
  - `ioctl_wait` is therefore high for exactly RD_LAT+1 cycles.
- Back-to-back reads: the next `ioctl_rd` may arrive in the first cycle `ioctl_wait` is low. Throughput is one byte per RD_LAT+2 cycles.
- `pause_ack` is registered as used: it raises in cycle A and READY/READ is entered in cycle A+1.
- Abort in READ: if `ioctl_upload` falls in READ, the in-flight byte is discarded. `ioctl_din` and `checksum` are unchanged, and `mem_q` arriving afterward is ignored.
- Reset mid-session: IDLE immediately and `pause_req` drops asynchronously. `done` is not pulsed.

## Structure
- Shared package `ioctl_pkg`:
  - state enum `upl_state_t` (IDLE, ACK, READY, READ);
  - constant `IOCTL_AW = 25`;
  - constant `OOR_BYTE = 8'hFF`.
- Single module; no sub-module is needed. RD_LAT is handled by a 2-bit down-counter in READ.

## Test plan
- Basic read: RAM[5]=8'h3C, RD_LAT=1; start session, ack after 3 cycles, `ioctl_rd` addr 5 -> `mem_rd` for 1 cycle with `mem_addr`=5, `ioctl_wait` high 2 cycles, then `ioctl_din`=8'h3C and `checksum`=8'h3C.
- Early request: `ioctl_rd` addr 7 while waiting for ack, ack at cycle 10 -> no `mem_rd` before the ack, a single read of addr 7 afterward, correct data returned.
- Out-of-range: addr 1024 with DEPTH=1024 -> `mem_rd` never asserted, `ioctl_din`=8'hFF, `ioctl_wait` high 2 cycles.
- Full dump: read all 1024 bytes back-to-back with RAM[i]=i[7:0] -> every byte correct, `checksum`=8'h00, one `done` pulse on `ioctl_upload` fall, `pause_req` low.
- Index mismatch: `ioctl_index`=3 with upload high and `ioctl_rd` pulses -> `pause_req`, `ioctl_wait` and `mem_rd` stay 0.
- Abort and reset: `ioctl_upload` drops during READ -> `checksum` and `ioctl_din` unchanged, `done` pulses. `reset_n` low mid-session -> all outputs 0 in the same cycle, no `done` pulse.
